// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: whole-line refill / writeback sequencer
// for a single-port word memory with 1-cycle read latency.
module mem_line_ctrl #(
  parameter int ADDR_LEN = 11,
  parameter int LINE_LEN = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req,
  input  logic                          req_wr,
  input  logic [ADDR_LEN-LINE_LEN-1:0]  req_line_addr,
  input  logic [32*(1<<LINE_LEN)-1:0]   wr_line,
  output logic [32*(1<<LINE_LEN)-1:0]   rd_line,
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_LEN-1:0]           mem_addr,
  output logic                          mem_wr_req,
  output logic [31:0]                   mem_wr_data,
  input  logic [31:0]                   mem_rd_data
);
  localparam int N  = 1 << LINE_LEN;
  localparam int LA = ADDR_LEN - LINE_LEN;
  localparam int CW = LINE_LEN + 1;
  localparam int IW = (LINE_LEN > 0) ? LINE_LEN : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ENDW = CW'(N);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } state_e;

  state_e             state_q, state_d;
  logic [LA-1:0]      line_addr_q, line_addr_d;
  logic [CW-1:0]      word_idx_q, word_idx_d;
  logic [CW-1:0]      cap_idx_q, cap_idx_d;
  logic [N-1:0][31:0] line_q, line_d;
  logic [IW-1:0]      wsel;
  logic [IW-1:0]      csel;
  logic [ADDR_LEN-1:0] word_addr;

  assign wsel = IW'(word_idx_q);
  assign csel = IW'(cap_idx_q);
  assign word_addr = (ADDR_LEN'(line_addr_q) << LINE_LEN)
                   | ADDR_LEN'(word_idx_q);

  assign rd_line = line_q;
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      word_idx_q  <= '0;
      cap_idx_q   <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      word_idx_q  <= word_idx_d;
      cap_idx_q   <= cap_idx_d;
      line_q      <= line_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    word_idx_d  = word_idx_q;
    cap_idx_d   = cap_idx_q;
    line_d      = line_q;
    done        = 1'b0;
    mem_addr    = '0;
    mem_wr_req  = 1'b0;
    mem_wr_data = '0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          line_addr_d = req_line_addr;
          line_d      = wr_line;
          word_idx_d  = '0;
          cap_idx_d   = '0;
          state_d     = req_wr ? WRITE : READ;
        end
      end
      WRITE: begin
        mem_wr_req  = 1'b1;
        mem_addr    = word_addr;
        mem_wr_data = line_q[wsel];
        word_idx_d  = word_idx_q + 1'b1;
        if (word_idx_q == LAST) state_d = RESP;
      end
      READ: begin
        if (word_idx_q != ENDW) begin
          mem_addr   = word_addr;
          word_idx_d = word_idx_q + 1'b1;
        end
        // data for the word issued last cycle arrives now
        if (word_idx_q != '0) begin
          line_d[csel] = mem_rd_data;
          cap_idx_d    = cap_idx_q + 1'b1;
          if (cap_idx_q == LAST) state_d = RESP;
        end
      end
      RESP: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
